multicycle_mips: RTL and testbench

MULTICYCLE_MIPS -- requirements
Module: multicycle_mips

---
 rtl/multicycle_mips.sv | 150 +++++++++++++++
 tb/tb_multicycle_mips.sv | 497 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_mips.sv
// Multicycle MIPS core: one shared instruction/data memory port, 32x32 register file.
// Define MULTICYCLE_MIPS_BNE_EN to add bne (opcode 0x05) on top of the base instruction set.
module multicycle_mips #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          MEM_ADDR_W = 13
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [MEM_ADDR_W-1:0] o_mem_addr,
    output logic [31:0]           o_mem_wdata,
    input  logic [31:0]           i_mem_rdata,
    input  logic                  i_mem_ready,
    output logic                  o_halt
);

    localparam logic [3:0] FETCH  = 4'd0;
    localparam logic [3:0] DECODE = 4'd1;
    localparam logic [3:0] MEMADR = 4'd2;
    localparam logic [3:0] MEMRD  = 4'd3;
    localparam logic [3:0] MEMWB  = 4'd4;
    localparam logic [3:0] MEMWR  = 4'd5;
    localparam logic [3:0] EXEC   = 4'd6;
    localparam logic [3:0] ALUWB  = 4'd7;
    localparam logic [3:0] ADDIEX = 4'd8;
    localparam logic [3:0] ADDIWB = 4'd9;
    localparam logic [3:0] BRANCH = 4'd10;
    localparam logic [3:0] JUMP   = 4'd11;
    localparam logic [3:0] HALT   = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    logic [3:0]  state_q, state_d;
    logic [31:0] pc_q, ir_q, a_q, b_q, alu_q, mdr_q;
    logic [31:0] rf_q [32];

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm_sext, alu_result;
    logic        funct_ok, branch_taken, mem_state;
    logic        unused_shamt;

    assign opcode       = ir_q[31:26];
    assign rs           = ir_q[25:21];
    assign rt           = ir_q[20:16];
    assign rd           = ir_q[15:11];
    assign funct        = ir_q[5:0];
    assign imm_sext     = {{16{ir_q[15]}}, ir_q[15:0]};
    assign unused_shamt = ^ir_q[10:6];

    always_comb begin
        funct_ok   = 1'b1;
        alu_result = 32'd0;
        case (funct)
            6'h20:   alu_result = a_q + b_q;
            6'h22:   alu_result = a_q - b_q;
            6'h24:   alu_result = a_q & b_q;
            6'h25:   alu_result = a_q | b_q;
            6'h2A:   alu_result = {31'd0, $signed(a_q) < $signed(b_q)};
            default: funct_ok = 1'b0;
        endcase
    end

`ifdef MULTICYCLE_MIPS_BNE_EN
    assign branch_taken = (opcode == OP_BNE) ? (a_q != b_q) : (a_q == b_q);
`else
    assign branch_taken = (a_q == b_q);
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:  if (i_mem_ready) state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = funct_ok ? EXEC : HALT;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_BEQ:       state_d = BRANCH;
`ifdef MULTICYCLE_MIPS_BNE_EN
                    OP_BNE:       state_d = BRANCH;
`endif
                    OP_J:         state_d = JUMP;
                    default:      state_d = HALT;
                endcase
            end
            MEMADR: state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  if (i_mem_ready) state_d = MEMWB;
            MEMWR:  if (i_mem_ready) state_d = FETCH;
            EXEC:   state_d = ALUWB;
            ADDIEX: state_d = ADDIWB;
            MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: state_d = FETCH;
            HALT:   state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 32'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            alu_q   <= 32'd0;
            mdr_q   <= 32'd0;
            for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
        end else begin
            state_q <= state_d;
            case (state_q)
                FETCH: begin
                    if (i_mem_ready) begin
                        ir_q <= i_mem_rdata;
                        pc_q <= pc_q + 32'd4;
                    end
                end
                DECODE: begin
                    a_q <= rf_q[rs];
                    b_q <= rf_q[rt];
                end
                MEMADR, ADDIEX: alu_q <= a_q + imm_sext;
                EXEC:           alu_q <= alu_result;
                MEMRD:  if (i_mem_ready) mdr_q <= i_mem_rdata;
                MEMWB:  if (rt != 5'd0) rf_q[rt] <= mdr_q;
                ALUWB:  if (rd != 5'd0) rf_q[rd] <= alu_q;
                ADDIWB: if (rt != 5'd0) rf_q[rt] <= alu_q;
                // pc_q already points past the branch when the offset is added
                BRANCH: if (branch_taken) pc_q <= pc_q + (imm_sext << 2);
                JUMP:   pc_q <= {pc_q[31:28], ir_q[25:0], 2'b00};
                default: ;
            endcase
        end
    end

    assign mem_state   = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
    // Reset forces the state to FETCH, so the request is also gated by reset itself
    assign o_mem_req   = mem_state && !i_rst;
    assign o_mem_we    = (state_q == MEMWR);
    assign o_mem_addr  = (state_q == FETCH) ? pc_q[MEM_ADDR_W+1:2] : alu_q[MEM_ADDR_W+1:2];
    assign o_mem_wdata = b_q;
    assign o_halt      = (state_q == HALT);

endmodule

// File: tb/tb_multicycle_mips.sv
// Bench for multicycle_mips: memory model, ISA-level reference model, scenario tasks.
// Honours MULTICYCLE_MIPS_BNE_EN the same way as the design.
module tb_multicycle_mips;

`ifdef MULTICYCLE_MIPS_BNE_EN
    localparam bit BNE_EN = 1'b1;
`else
    localparam bit BNE_EN = 1'b0;
`endif
    localparam logic [31:0] HALT_INS = 32'hFC00_0000;

    typedef struct packed {
        logic [12:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_we, mem_ready, halt;
    logic [12:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic [31:0] mem  [0:8191];
    logic [31:0] rmem [0:8191];
    wr_t         dut_wr[$];
    wr_t         exp_wr[$];

    int          n_checks = 0;
    int          n_fail = 0;
    int          cycle = 0;
    bit          rand_ready = 1'b0;
    bit          pend = 1'b0;
    logic [12:0] pend_addr;
    logic        pend_we;
    logic [31:0] pend_wdata;

    multicycle_mips #(
        .RESET_PC   (32'h0000_0000),
        .MEM_ADDR_W (13)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .o_mem_req   (mem_req),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata),
        .i_mem_ready (mem_ready),
        .o_halt      (halt)
    );

    always #5 clk = ~clk;
    assign mem_rdata = mem[mem_addr];

    function automatic logic [31:0] enc_r(int rs, int rt, int rd, logic [5:0] f);
        return {6'h00, rs[4:0], rt[4:0], rd[4:0], 5'd0, f};
    endfunction

    function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, logic [15:0] imm);
        return {op, rs[4:0], rt[4:0], imm};
    endfunction

    function automatic logic [31:0] enc_j(logic [25:0] target);
        return {6'h02, target};
    endfunction

    // One clock: sample bus before the edge, commit accepted writes after it.
    task automatic step();
        logic        fire, w;
        logic [12:0] a;
        logic [31:0] d;
        if (rand_ready) mem_ready = ($urandom_range(0, 3) != 0);
        if (!rst && pend) begin
            n_checks++;
            if (mem_req !== 1'b1 || mem_addr !== pend_addr || mem_we !== pend_we ||
                mem_wdata !== pend_wdata) begin
                n_fail++;
                $display("FAIL bus_stable: got req=%0b addr=%0h we=%0b wdata=%0h required req=1 addr=%0h we=%0b wdata=%0h",
                         mem_req, mem_addr, mem_we, mem_wdata, pend_addr, pend_we, pend_wdata);
            end
        end
        fire = !rst && mem_req && mem_ready;
        a = mem_addr;
        w = mem_we;
        d = mem_wdata;
        pend = !rst && mem_req && !mem_ready;
        pend_addr = a;
        pend_we = w;
        pend_wdata = d;
        @(posedge clk);
        #1;
        cycle++;
        if (fire && w) begin
            mem[a] = d;
            dut_wr.push_back('{addr: a, data: d});
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pend = 1'b0;
        step();
        step();
        rst = 1'b0;
        cycle = 0;
        dut_wr.delete();
    endtask

    task automatic run_dut(input int budget);
        while (halt !== 1'b1 && cycle < budget) step();
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 8192; i++) mem[i] = 32'd0;
    endtask

    // Instruction-set level model: executes the program image, returns zero-wait cycle count.
    task automatic ref_run(output int cycles);
        logic [31:0] r [32];
        logic [31:0] pc, ins, va, vb, sx, ea, res;
        logic [5:0]  op, f;
        for (int i = 0; i < 8192; i++) rmem[i] = mem[i];
        for (int i = 0; i < 32; i++) r[i] = 32'd0;
        pc = 32'd0;
        cycles = -1;
        exp_wr.delete();
        for (int n = 0, c = 0; n < 500; n++) begin
            ins = rmem[pc[14:2]];
            pc = pc + 4;
            op = ins[31:26];
            f = ins[5:0];
            va = r[ins[25:21]];
            vb = r[ins[20:16]];
            sx = {{16{ins[15]}}, ins[15:0]};
            ea = va + sx;
            if (op == 6'h00 && (f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25 ||
                                f == 6'h2A)) begin
                if (f == 6'h20) res = va + vb;
                else if (f == 6'h22) res = va - vb;
                else if (f == 6'h24) res = va & vb;
                else if (f == 6'h25) res = va | vb;
                else res = ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0;
                r[ins[15:11]] = res;
                c += 4;
            end else if (op == 6'h08) begin
                r[ins[20:16]] = ea;
                c += 4;
            end else if (op == 6'h23) begin
                r[ins[20:16]] = rmem[ea[14:2]];
                c += 5;
            end else if (op == 6'h2B) begin
                rmem[ea[14:2]] = vb;
                exp_wr.push_back('{addr: ea[14:2], data: vb});
                c += 4;
            end else if (op == 6'h04 || (BNE_EN && op == 6'h05)) begin
                if ((op == 6'h04) ? (va == vb) : (va != vb)) pc = pc + (sx << 2);
                c += 3;
            end else if (op == 6'h02) begin
                pc = {pc[31:28], ins[25:0], 2'b00};
                c += 3;
            end else begin
                cycles = c + 2;
                return;
            end
            r[0] = 32'd0;
        end
    endtask

    task automatic test_reset();
        clear_mem();
        mem[0] = HALT_INS;
        mem_ready = 1'b1;
        rst = 1'b1;
        step();
        n_checks += 2;
        if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0b required 0", mem_req); end
        if (halt !== 1'b0) begin n_fail++; $display("FAIL reset_halt: got %0b required 0", halt); end
        rst = 1'b0;
        cycle = 0;
        #1;
        n_checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_first_fetch: got req=%0b we=%0b addr=%0h required req=1 we=0 addr=0",
                     mem_req, mem_we, mem_addr);
        end
    endtask

    task automatic test_addi_add();
        int exp_cyc;
        clear_mem();
        mem[0] = enc_i(6'h08, 0, 1, 16'd5);
        mem[1] = enc_i(6'h08, 0, 2, 16'hFFFD);
        mem[2] = enc_r(1, 2, 3, 6'h20);
        mem[3] = enc_i(6'h2B, 0, 3, 16'h0080);
        mem[4] = HALT_INS;
        ref_run(exp_cyc);
        mem_ready = 1'b1;
        do_reset();
        repeat (12) step();
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 13'd3) begin
            n_fail++;
            $display("FAIL addi_add_pc: got req=%0b addr=%0h required req=1 addr=3", mem_req, mem_addr);
        end
        run_dut(200);
        n_checks += 2;
        if (dut_wr.size() != 1 || dut_wr[0] !== '{addr: 13'h20, data: 32'd2}) begin
            n_fail++;
            $display("FAIL addi_add_r3: got %0d writes first=%0h required 1 write {20,2}",
                     dut_wr.size(), (dut_wr.size() > 0) ? dut_wr[0] : '0);
        end
        if (cycle != exp_cyc) begin
            n_fail++;
            $display("FAIL addi_add_cycles: got %0d required %0d", cycle, exp_cyc);
        end
    endtask

    task automatic test_sw_lw();
        wr_t want [2];
        int  exp_cyc;
        want[0] = '{addr: 13'd2, data: 32'hDEADBEEF};
        want[1] = '{addr: 13'd3, data: 32'hDEADBEEF};
        clear_mem();
        mem[0]    = enc_j(26'h40);
        mem[8'hC0] = 32'hDEADBEEF;
        mem[8'h40] = enc_i(6'h23, 0, 1, 16'h0300);
        mem[8'h41] = enc_i(6'h2B, 0, 1, 16'h0008);
        mem[8'h42] = enc_i(6'h23, 0, 4, 16'h0008);
        mem[8'h43] = enc_i(6'h2B, 0, 4, 16'h000C);
        mem[8'h44] = HALT_INS;
        ref_run(exp_cyc);
        mem_ready = 1'b1;
        do_reset();
        run_dut(300);
        n_checks++;
        if (dut_wr.size() != 2 || cycle != exp_cyc) begin
            n_fail++;
            $display("FAIL sw_lw_count: got %0d writes in %0d cycles required 2 in %0d",
                     dut_wr.size(), cycle, exp_cyc);
        end
        for (int i = 0; i < 2 && i < dut_wr.size(); i++) begin
            n_checks++;
            if (dut_wr[i] !== want[i]) begin
                n_fail++;
                $display("FAIL sw_lw_data%0d: got %0h required %0h", i, dut_wr[i], want[i]);
            end
        end
    endtask

    task automatic test_branch_jump();
        clear_mem();
        mem[0]     = enc_j(26'h40);
        mem[8'h40] = enc_j(26'h4);
        mem[4]     = enc_i(6'h04, 0, 0, 16'hFFFF);
        mem_ready = 1'b1;
        do_reset();
        repeat (3) step();
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 13'h40) begin
            n_fail++;
            $display("FAIL jump_target: got req=%0b addr=%0h required req=1 addr=40", mem_req, mem_addr);
        end
        repeat (3) step();
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (mem_req !== 1'b1 || mem_addr !== 13'h4) begin
                n_fail++;
                $display("FAIL beq_loop%0d: got req=%0b addr=%0h required req=1 addr=4", k, mem_req, mem_addr);
            end
            step();
            n_checks++;
            if (mem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL beq_decode_req%0d: got %0b required 0", k, mem_req);
            end
            step();
            step();
        end
    endtask

    task automatic test_wait_states();
        clear_mem();
        mem[0] = enc_i(6'h08, 0, 1, 16'd9);
        mem[1] = enc_i(6'h2B, 0, 1, 16'h0080);
        mem[2] = HALT_INS;
        mem_ready = 1'b1;
        do_reset();
        mem_ready = 1'b0;
        repeat (3) begin
            step();
            n_checks++;
            if (mem_req !== 1'b1 || mem_addr !== 13'd0 || mem_we !== 1'b0) begin
                n_fail++;
                $display("FAIL wait_hold: got req=%0b addr=%0h we=%0b required req=1 addr=0 we=0",
                         mem_req, mem_addr, mem_we);
            end
        end
        mem_ready = 1'b1;
        repeat (4) step();
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 13'd1 || cycle != 7) begin
            n_fail++;
            $display("FAIL wait_complete: got req=%0b addr=%0h cycle=%0d required req=1 addr=1 cycle=7",
                     mem_req, mem_addr, cycle);
        end
        run_dut(200);
        n_checks++;
        if (dut_wr.size() != 1 || dut_wr[0] !== '{addr: 13'h20, data: 32'd9}) begin
            n_fail++;
            $display("FAIL wait_store: got %0d writes required 1 write {20,9}", dut_wr.size());
        end
    endtask

    task automatic test_halt();
        logic [31:0] bad [2];
        bad[0] = HALT_INS;
        bad[1] = enc_r(1, 2, 3, 6'h21);
        for (int t = 0; t < 2; t++) begin
            clear_mem();
            mem[0] = bad[t];
            mem_ready = 1'b1;
            do_reset();
            step();
            n_checks++;
            if (halt !== 1'b0) begin n_fail++; $display("FAIL halt_early%0d: got %0b required 0", t, halt); end
            step();
            n_checks++;
            if (halt !== 1'b1) begin n_fail++; $display("FAIL halt_set%0d: got %0b required 1", t, halt); end
            repeat (5) begin
                step();
                n_checks++;
                if (mem_req !== 1'b0 || halt !== 1'b1) begin
                    n_fail++;
                    $display("FAIL halt_absorb%0d: got req=%0b halt=%0b required req=0 halt=1", t, mem_req, halt);
                end
            end
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (halt !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_reset: got halt=%0b req=%0b required 0 0", halt, mem_req);
        end
        pend = 1'b0;
        step();
        rst = 1'b0;
        #1;
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 13'd0) begin
            n_fail++;
            $display("FAIL halt_refetch: got req=%0b addr=%0h required req=1 addr=0", mem_req, mem_addr);
        end
    endtask

    task automatic test_bne();
        int exp_cyc;
        clear_mem();
        mem[0] = enc_i(6'h08, 0, 1, 16'd1);
        mem[1] = enc_i(6'h05, 1, 0, 16'd2);
        mem[2] = HALT_INS;
        mem[3] = HALT_INS;
        mem[4] = enc_i(6'h2B, 0, 1, 16'h0040);
        mem[5] = HALT_INS;
        ref_run(exp_cyc);
        mem_ready = 1'b1;
        do_reset();
        run_dut(200);
        n_checks += 2;
        if (halt !== 1'b1 || cycle != exp_cyc) begin
            n_fail++;
            $display("FAIL bne_halt: got halt=%0b cycle=%0d required halt=1 cycle=%0d", halt, cycle, exp_cyc);
        end
        if (dut_wr.size() != (BNE_EN ? 1 : 0) ||
            (dut_wr.size() > 0 && dut_wr[0] !== '{addr: 13'h10, data: 32'd1})) begin
            n_fail++;
            $display("FAIL bne_taken: got %0d writes required %0d", dut_wr.size(), BNE_EN ? 1 : 0);
        end
    endtask

    task automatic test_mid_reset();
        clear_mem();
        mem[0] = enc_i(6'h08, 0, 1, 16'd7);
        mem[1] = enc_i(6'h2B, 0, 1, 16'h0080);
        mem[2] = HALT_INS;
        mem_ready = 1'b1;
        do_reset();
        repeat (7) step();
        mem_ready = 1'b0;
        repeat (2) step();
        n_checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 13'h20 || mem_wdata !== 32'd7) begin
            n_fail++;
            $display("FAIL mid_pending: got req=%0b we=%0b addr=%0h wdata=%0h required 1 1 20 7",
                     mem_req, mem_we, mem_addr, mem_wdata);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (mem_req !== 1'b0 || halt !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_req: got req=%0b halt=%0b required 0 0", mem_req, halt);
        end
        pend = 1'b0;
        step();
        rst = 1'b0;
        cycle = 0;
        mem_ready = 1'b1;
        mem[0] = enc_i(6'h2B, 0, 1, 16'h0080);
        mem[1] = HALT_INS;
        n_checks++;
        if (dut_wr.size() != 0) begin
            n_fail++;
            $display("FAIL mid_reset_nowrite: got %0d writes required 0", dut_wr.size());
        end
        run_dut(200);
        n_checks++;
        if (dut_wr.size() != 1 || dut_wr[0] !== '{addr: 13'h20, data: 32'd0}) begin
            n_fail++;
            $display("FAIL mid_reset_regs_clear: got %0d writes required 1 write {20,0}", dut_wr.size());
        end
    endtask

    task automatic gen_prog();
        logic [5:0] functs [5];
        int         n, k;
        functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        clear_mem();
        for (int i = 0; i < 64; i++) mem[13'h800 + i] = $urandom;
        n = $urandom_range(15, 30);
        for (int i = 0; i < n; i++) begin
            k = $urandom_range(0, 9);
            if (k <= 3)
                mem[i] = enc_r($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                               functs[$urandom_range(0, 4)]);
            else if (k <= 5 || k == 9)
                mem[i] = enc_i(6'h08, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom));
            else if (k <= 7)
                mem[i] = enc_i((k == 6) ? 6'h23 : 6'h2B, 0, $urandom_range(0, 7),
                               16'(32'h2000 + 4 * $urandom_range(0, 63)));
            else
                mem[i] = enc_i(6'h04, $urandom_range(0, 7), $urandom_range(0, 7), 16'd1);
        end
        for (int r = 1; r < 8; r++) mem[n + r - 1] = enc_i(6'h2B, 0, r, 16'(32'h3000 + 4 * r));
        mem[n + 7] = HALT_INS;
    endtask

    task automatic test_random();
        int exp_cyc;
        for (int it = 0; it < 6; it++) begin
            gen_prog();
            ref_run(exp_cyc);
            rand_ready = (it != 0);
            mem_ready = 1'b1;
            do_reset();
            run_dut(4000);
            rand_ready = 1'b0;
            n_checks++;
            if (halt !== 1'b1 || dut_wr.size() != exp_wr.size()) begin
                n_fail++;
                $display("FAIL rand%0d_end: got halt=%0b writes=%0d required halt=1 writes=%0d",
                         it, halt, dut_wr.size(), exp_wr.size());
            end
            for (int i = 0; i < exp_wr.size() && i < dut_wr.size(); i++) begin
                n_checks++;
                if (dut_wr[i] !== exp_wr[i]) begin
                    n_fail++;
                    $display("FAIL rand%0d_wr%0d: got %0h required %0h", it, i, dut_wr[i], exp_wr[i]);
                end
            end
            if (it == 0) begin
                n_checks++;
                if (cycle != exp_cyc) begin
                    n_fail++;
                    $display("FAIL rand_cycles: got %0d required %0d", cycle, exp_cyc);
                end
            end
        end
    endtask

    initial begin
        mem_ready = 1'b1;
        test_reset();
        test_addi_add();
        test_sw_lw();
        test_branch_jump();
        test_wait_states();
        test_halt();
        test_bne();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
